// File: rtl/demux1to4_stream_if.sv
// rtl/demux1to4_stream_if.sv - handshake bundle between a word source, the 1-to-4 distributor and its four lanes
//
// Signals:
//   IN_VALID / IN_READY / IN_DATA / IN_SEL  : tagged input word stream
//   OUT_VALID[3:0] / OUT_READY[3:0]         : per-lane handshake
//   OUT_DATA0..OUT_DATA3                    : head word of each lane
//   FILL                                    : per-lane occupancy, lane i at [i*CW +: CW]
// Modports:
//   master : source/sink side (drives IN_*, OUT_READY)
//   slave  : distributor side (drives IN_READY, OUT_VALID, OUT_DATAx, FILL)

interface demux1to4_stream_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_DATA;
    logic [1:0]       IN_SEL;
    logic [3:0]       OUT_VALID;
    logic [3:0]       OUT_READY;
    logic [WIDTH-1:0] OUT_DATA0;
    logic [WIDTH-1:0] OUT_DATA1;
    logic [WIDTH-1:0] OUT_DATA2;
    logic [WIDTH-1:0] OUT_DATA3;
    logic [4*CW-1:0]  FILL;

    modport master (
        output IN_VALID, IN_DATA, IN_SEL, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3, FILL
    );

    modport slave (
        input  IN_VALID, IN_DATA, IN_SEL, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3, FILL
    );
endinterface

// File: rtl/demux1to4_stream.sv
// rtl/demux1to4_stream.sv - registered 1-to-4 word distributor with a small FIFO per lane
//
// Ports:
//   CLK  : clock, all state on rising edge
//   RST  : synchronous active-high reset, clears pointers, counts and storage
//   bus  : demux1to4_stream_if.slave (tagged input stream, four output lanes, FILL)
//
// Each lane owns a circular FIFO. OUT_VALID and OUT_DATAx come straight from
// registers; the head word register is loaded with the next-state head so a word
// pushed at edge k is visible right after edge k.

module demux1to4_stream #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    demux1to4_stream_if.slave     bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [4][DEPTH];
    logic [PW-1:0]    wr_ptr_q [4];
    logic [PW-1:0]    wr_ptr_d [4];
    logic [PW-1:0]    rd_ptr_q [4];
    logic [PW-1:0]    rd_ptr_d [4];
    logic [CW-1:0]    count_q  [4];
    logic [CW-1:0]    count_d  [4];
    logic [WIDTH-1:0] head_q   [4];
    logic [WIDTH-1:0] head_d   [4];
    logic [3:0]       out_valid_q;
    logic [3:0]       out_valid_d;

    logic [3:0]       full;
    logic [3:0]       push_ch;
    logic [3:0]       pop_ch;
    logic             in_ready;
    logic             push;

    always_comb begin
        full = '0;
        for (int i = 0; i < 4; i++) begin
            full[i] = (count_q[i] == CW'(DEPTH));
        end
    end

    // Ready depends only on the addressed lane's registered fullness, so a pop
    // on a full lane frees the slot for the following cycle, not this one.
    assign in_ready = !full[bus.IN_SEL];
    assign push     = bus.IN_VALID && in_ready;

    always_comb begin
        push_ch     = '0;
        pop_ch      = '0;
        out_valid_d = '0;
        for (int i = 0; i < 4; i++) begin
            push_ch[i] = push && (bus.IN_SEL == 2'(i));
            pop_ch[i]  = out_valid_q[i] && bus.OUT_READY[i];

            wr_ptr_d[i] = push_ch[i] ? wr_ptr_q[i] + 1'b1 : wr_ptr_q[i];
            rd_ptr_d[i] = pop_ch[i]  ? rd_ptr_q[i] + 1'b1 : rd_ptr_q[i];

            case ({push_ch[i], pop_ch[i]})
                2'b10:   count_d[i] = count_q[i] + 1'b1;
                2'b01:   count_d[i] = count_q[i] - 1'b1;
                default: count_d[i] = count_q[i];
            endcase

            out_valid_d[i] = (count_d[i] != '0);

            // The slot being written becomes the head only when the lane holds
            // exactly this word afterwards; storage is not yet updated, so
            // forward the input word in that case.
            if (push_ch[i] && (wr_ptr_q[i] == rd_ptr_d[i])) begin
                head_d[i] = bus.IN_DATA;
            end else begin
                head_d[i] = mem_q[i][rd_ptr_d[i]];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                head_q[i]   <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
            out_valid_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
                head_q[i]   <= head_d[i];
                if (push_ch[i]) begin
                    mem_q[i][wr_ptr_q[i]] <= bus.IN_DATA;
                end
            end
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        bus.FILL = '0;
        for (int i = 0; i < 4; i++) begin
            bus.FILL[i*CW +: CW] = count_q[i];
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_DATA0 = head_q[0];
    assign bus.OUT_DATA1 = head_q[1];
    assign bus.OUT_DATA2 = head_q[2];
    assign bus.OUT_DATA3 = head_q[3];

endmodule
